// File: rtl/debouncer.sv
// debouncer: single-input synchronous level debouncer.
// The output follows the input only after the input has differed from the
// current output for 2^p_CNT_WIDTH consecutive clock samples. Any shorter
// excursion is ignored and its partial count is discarded. The input must
// already be synchronised to i_clk.
module debouncer #(
  parameter int p_CNT_WIDTH = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_input,
  output logic o_output
);

  localparam logic [p_CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [p_CNT_WIDTH-1:0] CNT_ONE  = p_CNT_WIDTH'(1);

  // Both registers power up at zero so an unreset simulation starts with a low output.
  logic [p_CNT_WIDTH-1:0] cnt   = '0;
  logic                   out_q = 1'b0;
  logic                   differs;

  // The counter saturates at all-ones, which is the commit point rather than a wrap.
  function automatic logic cnt_done(input logic [p_CNT_WIDTH-1:0] c);
    return &c;
  endfunction

  // A sample that differs from the committed level extends the current excursion.
  assign differs = i_input ^ out_q;

  // Stability counter and output register: restart on agreement, commit on a full run.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt   <= CNT_ZERO;
      out_q <= 1'b0;
    end else if (!differs) begin
      cnt   <= CNT_ZERO;
    end else if (!cnt_done(cnt)) begin
      cnt   <= cnt + CNT_ONE;
    end else begin
      out_q <= i_input;
      cnt   <= CNT_ZERO;
    end
  end

  // Output comes straight from its register, so it cannot glitch with the input.
  assign o_output = out_q;

endmodule

// File: tb/tb_debouncer.sv
// tb_debouncer: directed bench for the debouncer at widths 2 and 16.
// A history-based model (output flips once the last 2^N samples all differ
// from it) is compared against the width-2 instance on every falling edge;
// literal expectations pin the latency, rejection, restart and reset cases.
module tb_debouncer;

  logic clk = 1'b0;
  logic rst2_n, in2, out2;
  logic rst16_n, in16, out16;

  int checks   = 0;
  int failures = 0;

  // Model state for the width-2 instance.
  logic m_out = 1'b0;
  logic hist[$];
  bit   rej_active = 1'b0;

  debouncer #(.p_CNT_WIDTH(2)) dut2 (
    .i_clk    (clk),
    .i_rst_n  (rst2_n),
    .i_input  (in2),
    .o_output (out2)
  );

  debouncer #(.p_CNT_WIDTH(16)) dut16 (
    .i_clk    (clk),
    .i_rst_n  (rst16_n),
    .i_input  (in16),
    .o_output (out16)
  );

  always #1 clk = ~clk;

  // Model: the output flips when the four most recent samples all disagree with it.
  always @(posedge clk) begin
    if (!rst2_n) begin
      m_out = 1'b0;
      hist.delete();
    end else begin
      hist.push_back(in2);
      if (hist.size() > 4) void'(hist.pop_front());
      if (hist.size() == 4) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int i = 0; i < 4; i++) if (hist[i] == m_out) all_diff = 1'b0;
        if (all_diff) begin
          m_out = ~m_out;
          hist.delete();
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checks++;
    if (out2 !== m_out) begin
      failures++;
      $display("FAIL model_cmp t=%0t actual=%0b required=%0b", $time, out2, m_out);
    end
  end

  // Any output movement during the rejection phase is an error.
  always @(out2) begin
    if (rej_active) begin
      failures++;
      $display("FAIL rejection_watchdog t=%0t actual=%0b required=0", $time, out2);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0b required=%0b", name, $time, act, exp);
    end
  endtask

  initial begin
    logic nxt;
    rst2_n  = 1'b0;
    in2     = 1'b1;
    rst16_n = 1'b1;
    in16    = 1'b0;

    // Setup: reset held for two cycles with the input high.
    chk("powerup16", out16, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("reset_hold", out2, 1'b0);
    end
    rst2_n = 1'b1;
    in2    = 1'b0;
    step();
    chk("after_release", out2, 1'b0);

    // Rejection: three-sample excursions never reach the commit point.
    rej_active = 1'b1;
    for (int r = 0; r < 10; r++) begin
      in2 = 1'b1;
      repeat (3) step();
      in2 = 1'b0;
      step();
      chk("reject_iter", out2, 1'b0);
    end
    rej_active = 1'b0;

    // Acceptance: exactly four edges from toggle to output change, both directions.
    for (int t = 0; t < 10; t++) begin
      nxt = ~out2;
      in2 = nxt;
      for (int e = 1; e <= 3; e++) begin
        step();
        chk("accept_hold", out2, ~nxt);
      end
      step();
      chk("accept_commit", out2, nxt);
    end
    chk("accept_final", out2, 1'b0);

    // Counter restart: 1,1,0 then 1 held; output rises on the fourth edge of the final run.
    in2 = 1'b1;
    repeat (2) step();
    in2 = 1'b0;
    step();
    chk("restart_mid", out2, 1'b0);
    in2 = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      chk("restart_hold", out2, 1'b0);
    end
    step();
    chk("restart_commit", out2, 1'b1);

    // Mid-count reset: return to 0, count three samples, reset, then re-qualify.
    in2 = 1'b0;
    repeat (4) step();
    chk("midrst_prep", out2, 1'b0);
    in2 = 1'b1;
    repeat (3) step();
    chk("midrst_partial", out2, 1'b0);
    rst2_n = 1'b0;
    step();
    chk("midrst_in_reset", out2, 1'b0);
    rst2_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      chk("midrst_hold", out2, 1'b0);
    end
    step();
    chk("midrst_commit", out2, 1'b1);

    // Default width: 65535 edges are not enough, the 65536th commits.
    in16 = 1'b1;
    repeat (65535) step();
    chk("w16_before", out16, 1'b0);
    step();
    chk("w16_commit", out16, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
